// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state, frame and rate definitions
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - per-bit clock-enable divider, held clear while disabled
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Enable rather than a toggled clock: everything stays on clk.
    assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART transmitter, one byte per accepted request
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD         = DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        bit_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (state != IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    bit_idx <= '0;
                    if (tx_start) begin
                        shift   <= tx_data;
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end
                end
                STOP: begin
                    // Dropping busy with done lets a held tx_start restart after one idle cycle.
                    if (bit_tick) begin
                        state   <= IDLE;
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_byte.sv
// tb/tb_uart_tx_byte.sv - scoreboard bench for uart_tx_byte
module tb_uart_tx_byte;

    localparam int N = 4;
    localparam int DEF_BIT = 50_000_000 / 9600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_busy, tx_done;

    logic       rst_d = 1'b1;
    logic       start_d = 1'b0;
    logic [7:0] data_d = 8'h00;
    logic       tx_d, busy_d, done_d;

    int  tests = 0;
    int  fails = 0;
    bit  def_finished = 1'b0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_byte #(.CLKS_PER_BIT(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    uart_tx_byte dut_def (
        .clk      (clk),
        .rst      (rst_d),
        .tx_start (start_d),
        .tx_data  (data_d),
        .tx       (tx_d),
        .tx_busy  (busy_d),
        .tx_done  (done_d)
    );

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: decodes every frame off the line against the next queued byte.
    bit         in_frame = 1'b0;
    bit         expect_done = 1'b0;
    int         pos = 0;
    logic [9:0] frame = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame    = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (!in_frame) begin
                if (expect_done) begin
                    chk("done_pulse", int'(tx_done), 1);
                    expect_done = 1'b0;
                end else if (tx_done) begin
                    chk("stray_done", int'(tx_done), 0);
                end
                if (tx_busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        frame    = {1'b1, exp_q.pop_front(), 1'b0};
                        in_frame = 1'b1;
                        pos      = 0;
                    end
                end else begin
                    chk("idle_line", int'(tx), 1);
                end
            end
            if (in_frame) begin
                chk("frame_bit", int'(tx), int'(frame[pos / N]));
                chk("frame_busy", int'(tx_busy), 1);
                pos++;
                if (pos == 10 * N) begin
                    in_frame    = 1'b0;
                    expect_done = 1'b1;
                end
            end
        end
    end

    task automatic send_pulse(input logic [7:0] b);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = b;
        exp_q.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!tx_done && n < 20 * N) begin
            @(negedge clk);
            n++;
        end
        if (!tx_done) chk("done_timeout", 0, 1);
    endtask

    initial begin : def_test
        int cyc;
        int last_change;
        logic prev;
        repeat (3) @(negedge clk);
        rst_d = 1'b0;
        @(negedge clk);
        start_d = 1'b1;
        data_d  = 8'h55;
        @(negedge clk);
        start_d = 1'b0;
        cyc = 0;
        last_change = 0;
        prev = 1'b0;
        while (busy_d && cyc < 60000) begin
            if (tx_d != prev) begin
                chk("def_bit_len", cyc - last_change, DEF_BIT);
                last_change = cyc;
                prev = tx_d;
            end
            cyc++;
            @(negedge clk);
        end
        chk("def_stop_len", cyc - last_change, DEF_BIT);
        chk("def_frame_len", cyc, 10 * DEF_BIT);
        chk("def_done", int'(done_d), 1);
        def_finished = 1'b1;
    end

    initial begin : stim
        int wait_n;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_done", int'(tx_done), 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tx", int'(tx), 1);
            chk("idle_busy", int'(tx_busy), 0);
            chk("idle_done", int'(tx_done), 0);
        end

        send_pulse(8'hA5);
        wait_done();

        // Held start: second byte presented in the done cycle.
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h0F;
        exp_q.push_back(8'h0F);
        @(negedge clk);
        wait_done();
        tx_data = 8'hF0;
        exp_q.push_back(8'hF0);
        @(negedge clk);
        chk("b2b_gap_busy", int'(tx_busy), 1);
        chk("b2b_gap_tx", int'(tx), 0);
        tx_start = 1'b0;
        wait_done();

        send_pulse(8'h00);
        repeat (9) @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_start = 1'b0;
        wait_done();

        send_pulse(8'hC3);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", int'(tx), 1);
        chk("async_rst_busy", int'(tx_busy), 0);
        chk("async_rst_done", int'(tx_done), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_pulse(8'h3C);
        wait_done();

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            b = 8'($urandom);
            send_pulse(b);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
                tx_start = 1'b1;
                tx_data  = 8'($urandom);
                @(negedge clk);
                tx_start = 1'b0;
            end
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        wait_n = 0;
        while (!def_finished && wait_n < 60000) begin
            @(negedge clk);
            wait_n++;
        end
        chk("def_finished", int'(def_finished), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
